// File: rtl/deser400_phase_scan.sv
// Phase-calibration sequencer: sweeps each selected deser400 channel through every phase,
// measures the XOR sum over one gate window per phase, then programs the lowest-sum phase.
module deser400_phase_scan #(
    parameter int          NPHASE  = 8,
    parameter int          SETTLE  = 64,
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  ch_mask,
    input  logic        gate,
    input  logic [31:0] xorsum,
    output logic        gate_single,
    output logic [3:0]  phwrite,
    output logic [3:0]  phdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] best_phase,
    output logic [31:0] best_sum,
    output logic [3:0]  ch_err
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SEL, ST_WRITE, ST_SETTLE, ST_TRIG, ST_WAITHI,
        ST_WAITLO, ST_SAMPLE, ST_NEXT, ST_APPLY, ST_FIN
    } state_t;

    localparam logic [3:0]  LAST_PH   = 4'(NPHASE - 1);
    localparam logic [23:0] SETTLE_M1 = 24'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  ch_q, ch_d;
    logic [3:0]  phase_q, phase_d;
    logic [7:0]  min_q, min_d;
    logic [3:0]  best_q, best_d;
    logic [23:0] cnt_q, cnt_d;
    logic        gate_single_q, gate_single_d;
    logic [3:0]  phwrite_q, phwrite_d;
    logic [3:0]  phdata_q, phdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] best_phase_q, best_phase_d;
    logic [31:0] best_sum_q, best_sum_d;
    logic [3:0]  ch_err_q, ch_err_d;
    logic [1:0]  low_ch;
    logic [7:0]  s;

    always_comb begin
        low_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i]) low_ch = 2'(i);
        end
    end

    always_comb begin
        case (ch_q)
            2'd0:    s = xorsum[7:0];
            2'd1:    s = xorsum[15:8];
            2'd2:    s = xorsum[23:16];
            default: s = xorsum[31:24];
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        ch_d          = ch_q;
        phase_d       = phase_q;
        min_d         = min_q;
        best_d        = best_q;
        cnt_d         = cnt_q;
        gate_single_d = 1'b0;
        phwrite_d     = 4'd0;
        phdata_d      = phdata_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        best_phase_d  = best_phase_q;
        best_sum_d    = best_sum_q;
        ch_err_d      = ch_err_q;

        // Strobes are raised on the transition into their state so that the
        // registered outputs line up with the state that owns them.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d   = ch_mask;
                    ch_err_d = ch_err_q & ~ch_mask;
                    busy_d   = 1'b1;
                    state_d  = ST_SEL;
                end
            end
            ST_SEL: begin
                if (mask_q == 4'd0) begin
                    state_d = ST_FIN;
                end else begin
                    ch_d      = low_ch;
                    mask_d    = mask_q & ~(4'b0001 << low_ch);
                    phase_d   = 4'd0;
                    min_d     = 8'hFF;
                    best_d    = 4'd0;
                    phwrite_d = 4'b0001 << low_ch;
                    phdata_d  = 4'd0;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_d   = 24'd0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_M1) begin
                    gate_single_d = 1'b1;
                    state_d       = ST_TRIG;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_TRIG: begin
                cnt_d   = 24'd0;
                state_d = ST_WAITHI;
            end
            ST_WAITHI, ST_WAITLO: begin
                if ((state_q == ST_WAITHI) ? gate : !gate) begin
                    cnt_d   = 24'd0;
                    state_d = (state_q == ST_WAITHI) ? ST_WAITLO : ST_SAMPLE;
                end else if (cnt_q == TIMEOUT) begin
                    ch_err_d[ch_q] = 1'b1;
                    state_d        = ST_SEL;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_SAMPLE: begin
                if (s < min_q) begin
                    min_d  = s;
                    best_d = phase_q;
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                phwrite_d = 4'b0001 << ch_q;
                if (phase_q == LAST_PH) begin
                    phdata_d                        = best_q;
                    best_phase_d[{ch_q, 2'b00} +: 4] = best_q;
                    best_sum_d[{ch_q, 3'b000} +: 8]  = min_q;
                    state_d                         = ST_APPLY;
                end else begin
                    phase_d  = phase_q + 4'd1;
                    phdata_d = phase_q + 4'd1;
                    state_d  = ST_WRITE;
                end
            end
            ST_APPLY: state_d = ST_SEL;
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a start seen in the same cycle.
        if (abort) begin
            state_d       = ST_IDLE;
            mask_d        = 4'd0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            gate_single_d = 1'b0;
            phwrite_d     = 4'd0;
            phdata_d      = phdata_q;
            best_phase_d  = best_phase_q;
            best_sum_d    = best_sum_q;
            ch_err_d      = ch_err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mask_q        <= 4'd0;
            ch_q          <= 2'd0;
            phase_q       <= 4'd0;
            min_q         <= 8'd0;
            best_q        <= 4'd0;
            cnt_q         <= 24'd0;
            gate_single_q <= 1'b0;
            phwrite_q     <= 4'd0;
            phdata_q      <= 4'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            best_phase_q  <= 16'd0;
            best_sum_q    <= 32'd0;
            ch_err_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            ch_q          <= ch_d;
            phase_q       <= phase_d;
            min_q         <= min_d;
            best_q        <= best_d;
            cnt_q         <= cnt_d;
            gate_single_q <= gate_single_d;
            phwrite_q     <= phwrite_d;
            phdata_q      <= phdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            best_phase_q  <= best_phase_d;
            best_sum_q    <= best_sum_d;
            ch_err_q      <= ch_err_d;
        end
    end

    assign gate_single = gate_single_q;
    assign phwrite     = phwrite_q;
    assign phdata      = phdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign best_phase  = best_phase_q;
    assign best_sum    = best_sum_q;
    assign ch_err      = ch_err_q;

endmodule

// File: doc/deser400_phase_scan.md
# deser400_phase_scan

Automatic phase-calibration sequencer for the four deser400 channels. On a start request it scans each selected channel through every phase setting. For each setting it measures the phase-detector XOR sum over one single-shot gate window, then programs the phase with the lowest sum. It sits beside the deser400 register block and drives the same phase-write, phase-data and single-gate signals that software otherwise drives through registers 0 and 4.

## Interface
- NPHASE, 8: number of phase settings scanned, 0..NPHASE-1; legal range 2..16.
- SETTLE, 64: idle cycles after each phase write before the gate is triggered; legal range 1..65535.
- TIMEOUT, 24'hFFFFFF: maximum cycles to wait for the gate to rise, and then to fall, before the channel is aborted.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle start request; ignored while busy.
- abort  in  1  synchronous abort; has priority over every state.
- ch_mask  in  4  channels to scan (bit0 = I … bit3 = IV); sampled on start.
- gate  in  1  gate output of the gate generator.
- xorsum  in  32  {xorsum_IV, xorsum_III, xorsum_II, xorsum_I}, unsigned 8 bits each.
- gate_single  out  1  one-cycle single-trigger pulse to the gate generator.
- phwrite  out  4  one-hot phase-write strobe, one cycle long.
- phdata  out  4  phase value qualified by phwrite.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse when the scan is complete.
- best_phase  out  16  {IV, III, II, I}, 4 bits each; the phase chosen per channel.
- best_sum  out  32  minimum xorsum per channel, packed as xorsum.
- ch_err  out  4  per-channel timeout flags.

## Operation
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, SEL, WRITE, SETTLE, TRIG, WAITHI, WAITLO, SAMPLE, NEXT, APPLY, FIN.
- IDLE:
  - On start, latch ch_mask into mask_r.
  - Clear ch_err bits for the selected channels only; leave the other bits unchanged.
  - Go to SEL.
- SEL:
  - Select the lowest set bit of mask_r as ch, clear that bit, set phase = 0 and min = 8'hFF, then go to WRITE.
  - If mask_r = 0, go to FIN.
- WRITE: assert phwrite[ch] = 1 and phdata = phase for one cycle, then go to SETTLE.
- SETTLE: count SETTLE cycles, then go to TRIG.
- TRIG: assert gate_single for one cycle, then go to WAITHI.
- WAITHI: wait for gate = 1, then go to WAITLO.
- WAITLO: wait for gate = 0, then go to SAMPLE.
- SAMPLE:
  - s = xorsum[8*ch+7 : 8*ch].
  - If s < min (strict), set min = s and best = phase; ties keep the lower phase.
  - Go to NEXT.
- NEXT: if phase = NPHASE-1, go to APPLY; else phase++ and go to WRITE.
- APPLY:
  - Pulse phwrite[ch] with phdata = best.
  - Store best_phase[ch] and best_sum[ch] = min.
  - Go to SEL.
- FIN: pulse done, then go to IDLE.
- Timeout:
  - One counter, cleared on entry to WAITHI and to WAITLO.
  - When it reaches TIMEOUT: set ch_err[ch], leave best_phase[ch] and best_sum[ch] unchanged, issue no APPLY write, and go to SEL.
- Abort:
  - Go to IDLE on the next clock; busy falls and done is not pulsed.
  - Clear mask_r.
  - Keep already-stored results; issue no further phwrite.
- Outputs are registered.
  - phdata holds its last value outside phwrite pulses.
  - gate_single and phwrite are never asserted in IDLE.

## Timing
- start → busy = 1 on the next cycle.
- First phwrite occurs 2 cycles after start (IDLE → SEL → WRITE).
- phwrite to gate_single spacing: exactly SETTLE+1 cycles.
- SAMPLE captures xorsum in the cycle after gate is seen low.
- APPLY phwrite precedes the next channel's first phwrite by 2 cycles.
- ch_mask = 0: done pulses 3 cycles after start (SEL → FIN → done).
- start in the same cycle as abort: abort wins and start is ignored.
- Reset mid-scan: all outputs return to 0 immediately (asynchronous).

## Test plan
- Single channel:
  - Stimulus: ch_mask = 4'b0001; gate model with a 10-cycle high window; xorsum_I per phase = {40,30,12,55,12,70,80,90}.
  - Required: 8 scan writes with phdata 0..7, then an APPLY write with phdata = 2; best_phase[3:0] = 2; best_sum[7:0] = 12; one done pulse.
- All four channels:
  - Stimulus: ch_mask = 4'hF; distinct minima at phases 7, 0, 4, 5.
  - Required: channels visited in order I…IV; best_phase = 16'h5407; 36 phwrite pulses total.
- Timeout:
  - Stimulus: TIMEOUT = 100; gate stuck low for channel II; ch_mask = 4'b0110.
  - Required: ch_err = 4'b0010 with no APPLY write to channel II; channel III completes normally.
- Abort:
  - Stimulus: raise abort during SETTLE of phase 3.
  - Required: busy = 0 the next cycle; no done pulse; no further gate_single.
  - Follow-up: a new start rescans from phase 0.
- Settle spacing and start while busy:
  - Stimulus: SETTLE = 5; pulse start again while busy.
  - Required: phwrite → gate_single is exactly 6 cycles every time; the second start is ignored.
- Empty mask and reset:
  - Stimulus: ch_mask = 0.
  - Required: done 3 cycles after start with no phwrite.
  - Stimulus: assert reset mid-scan.
  - Required: all outputs return to 0 immediately.
